// File: rtl/tile_tcdm_xbar.sv
// Core-to-bank TCDM crossbar: per-bank round-robin arbitration with a fixed
// one-cycle response path back to each core.
module tile_tcdm_xbar #(
    parameter int NumCores      = 4,
    parameter int NumBanks      = 16,
    parameter int DataWidth     = 32,
    parameter int BankAddrWidth = 10,
    localparam int BeWidth      = DataWidth / 8
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [NumCores-1:0]                     core_req_i,
    input  logic [NumCores-1:0][31:0]               core_addr_i,
    input  logic [NumCores-1:0]                     core_wen_i,
    input  logic [NumCores-1:0][DataWidth-1:0]      core_wdata_i,
    input  logic [NumCores-1:0][BeWidth-1:0]        core_be_i,
    output logic [NumCores-1:0]                     core_gnt_o,
    output logic [NumCores-1:0]                     core_rvalid_o,
    output logic [NumCores-1:0][DataWidth-1:0]      core_rdata_o,
    output logic [NumBanks-1:0]                     bank_req_o,
    output logic [NumBanks-1:0][BankAddrWidth-1:0]  bank_addr_o,
    output logic [NumBanks-1:0]                     bank_wen_o,
    output logic [NumBanks-1:0][DataWidth-1:0]      bank_wdata_o,
    output logic [NumBanks-1:0][BeWidth-1:0]        bank_be_o,
    input  logic [NumBanks-1:0][DataWidth-1:0]      bank_rdata_i
);

    localparam int ByteOffset = $clog2(BeWidth);
    localparam int BankSelW   = $clog2(NumBanks);
    localparam int CoreW      = (NumCores > 1) ? $clog2(NumCores) : 1;

    logic [NumCores-1:0][BankSelW-1:0]      w_core_bank;
    logic [NumCores-1:0][BankAddrWidth-1:0] w_core_row;
    logic [NumBanks-1:0]                    w_bank_gnt;
    logic [NumBanks-1:0][CoreW-1:0]         w_bank_idx;
    logic                                   w_unused_addr;

    assign w_unused_addr = ^core_addr_i;

    for (genvar gi = 0; gi < NumCores; gi++) begin : g_core
        logic                r_resp_valid;
        logic                r_resp_we;
        logic [BankSelW-1:0] r_resp_bank;

        assign w_core_bank[gi] = core_addr_i[gi][ByteOffset +: BankSelW];
        assign w_core_row[gi]  = core_addr_i[gi][ByteOffset + BankSelW +: BankAddrWidth];

        // A core wins only if the bank it targets picked it this cycle.
        assign core_gnt_o[gi] = core_req_i[gi] & w_bank_gnt[w_core_bank[gi]]
                              & (w_bank_idx[w_core_bank[gi]] == CoreW'(gi));

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_resp_valid <= 1'b0;
                r_resp_we    <= 1'b0;
                r_resp_bank  <= '0;
            end else begin
                r_resp_valid <= core_gnt_o[gi];
                r_resp_we    <= core_wen_i[gi];
                r_resp_bank  <= w_core_bank[gi];
            end
        end

        assign core_rvalid_o[gi] = r_resp_valid & ~rst_i;
        assign core_rdata_o[gi]  = (r_resp_valid & ~r_resp_we & ~rst_i)
                                 ? bank_rdata_i[r_resp_bank] : '0;
    end

    for (genvar gi = 0; gi < NumBanks; gi++) begin : g_bank
        logic [NumCores-1:0] w_hit;
        logic                w_found_hi;
        logic                w_found_lo;
        logic [CoreW-1:0]    w_idx_hi;
        logic [CoreW-1:0]    w_idx_lo;
        logic [CoreW-1:0]    w_idx;
        logic [CoreW-1:0]    r_rr;

        // Cyclic search from r_rr: lowest hit at or above the pointer, else
        // the lowest hit overall (the wrap-around case).
        always_comb begin
            w_hit      = '0;
            w_found_hi = 1'b0;
            w_found_lo = 1'b0;
            w_idx_hi   = '0;
            w_idx_lo   = '0;
            for (int c = 0; c < NumCores; c++) begin
                w_hit[c] = core_req_i[c] && (w_core_bank[c] == BankSelW'(gi));
            end
            for (int c = NumCores - 1; c >= 0; c--) begin
                if (w_hit[c]) begin
                    w_found_lo = 1'b1;
                    w_idx_lo   = CoreW'(c);
                    if (CoreW'(c) >= r_rr) begin
                        w_found_hi = 1'b1;
                        w_idx_hi   = CoreW'(c);
                    end
                end
            end
        end

        assign w_idx          = w_found_hi ? w_idx_hi : w_idx_lo;
        assign w_bank_gnt[gi] = w_found_lo & ~rst_i;
        assign w_bank_idx[gi] = w_idx;

        assign bank_req_o[gi]   = w_bank_gnt[gi];
        assign bank_addr_o[gi]  = w_bank_gnt[gi] ? w_core_row[w_idx]   : '0;
        assign bank_wen_o[gi]   = w_bank_gnt[gi] & core_wen_i[w_idx];
        assign bank_wdata_o[gi] = w_bank_gnt[gi] ? core_wdata_i[w_idx] : '0;
        assign bank_be_o[gi]    = w_bank_gnt[gi] ? core_be_i[w_idx]    : '0;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_rr <= '0;
            end else if (w_bank_gnt[gi]) begin
                r_rr <= (w_idx == CoreW'(NumCores - 1)) ? '0 : w_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tile_tcdm_xbar.sv
// Self-checking bench for tile_tcdm_xbar: vector table, directed corner
// sequences and a randomized run against a behavioural arbitration model.
module tb_tile_tcdm_xbar;

    localparam int NC = 4;
    localparam int NB = 16;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int AW = 10;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NC-1:0]            core_req;
    logic [NC-1:0][31:0]      core_addr;
    logic [NC-1:0]            core_wen;
    logic [NC-1:0][DW-1:0]    core_wdata;
    logic [NC-1:0][BW-1:0]    core_be;
    logic [NC-1:0]            core_gnt;
    logic [NC-1:0]            core_rvalid;
    logic [NC-1:0][DW-1:0]    core_rdata;
    logic [NB-1:0]            bank_req;
    logic [NB-1:0][AW-1:0]    bank_addr;
    logic [NB-1:0]            bank_wen;
    logic [NB-1:0][DW-1:0]    bank_wdata;
    logic [NB-1:0][BW-1:0]    bank_be;
    logic [NB-1:0][DW-1:0]    bank_rdata;

    always #5 clk = ~clk;

    tile_tcdm_xbar #(
        .NumCores(NC), .NumBanks(NB), .DataWidth(DW), .BankAddrWidth(AW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .core_req_i(core_req), .core_addr_i(core_addr), .core_wen_i(core_wen),
        .core_wdata_i(core_wdata), .core_be_i(core_be),
        .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
        .bank_req_o(bank_req), .bank_addr_o(bank_addr), .bank_wen_o(bank_wen),
        .bank_wdata_o(bank_wdata), .bank_be_o(bank_be), .bank_rdata_i(bank_rdata)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        core_req   = '0;
        core_addr  = '0;
        core_wen   = '0;
        core_wdata = '0;
        core_be    = '0;
        bank_rdata = '0;
    endtask

    task automatic set_core(input int c, input logic [31:0] a, input logic w,
                            input logic [31:0] d, input logic [3:0] be);
        core_req[c]   = 1'b1;
        core_addr[c]  = a;
        core_wen[c]   = w;
        core_wdata[c] = d;
        core_be[c]    = be;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("rst_gnt", 64'(core_gnt), 64'h0);
        chk("rst_rvalid", 64'(core_rvalid), 64'h0);
        chk("rst_bank_req", 64'(bank_req), 64'h0);
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [NC-1:0]      req;
        logic [NC-1:0][3:0] bank;
        logic [NC-1:0]      exp_gnt;
        logic [NB-1:0]      exp_breq;
    } vec_t;

    vec_t vecs[6];

    int          m_rr[NB];
    bit          m_pv[NC];
    int          m_pb[NC];
    bit          m_pw[NC];
    logic [NC-1:0] m_gnt;
    logic [NC-1:0] last_gnt;
    int          win;
    int          bsel;

    initial begin
        rst = 1'b1;
        idle();

        vecs[0] = '{req: 4'b0001, bank: {4'd0, 4'd0, 4'd0, 4'd1}, exp_gnt: 4'b0001, exp_breq: 16'h0002};
        vecs[1] = '{req: 4'b1111, bank: {4'd3, 4'd2, 4'd1, 4'd0}, exp_gnt: 4'b1111, exp_breq: 16'h000F};
        vecs[2] = '{req: 4'b1111, bank: {4'd5, 4'd5, 4'd5, 4'd5}, exp_gnt: 4'b0001, exp_breq: 16'h0020};
        vecs[3] = '{req: 4'b1110, bank: {4'd2, 4'd7, 4'd7, 4'd0}, exp_gnt: 4'b1010, exp_breq: 16'h0084};
        vecs[4] = '{req: 4'b1100, bank: {4'd4, 4'd4, 4'd3, 4'd3}, exp_gnt: 4'b0100, exp_breq: 16'h0010};
        vecs[5] = '{req: 4'b0000, bank: {4'd1, 4'd1, 4'd1, 4'd1}, exp_gnt: 4'b0000, exp_breq: 16'h0000};

        for (int v = 0; v < 6; v++) begin
            do_reset();
            for (int c = 0; c < NC; c++) begin
                if (vecs[v].req[c])
                    set_core(c, (32'(c) << 6) | (32'(vecs[v].bank[c]) << 2), 1'b0, 32'h0, 4'hF);
            end
            @(negedge clk);
            chk($sformatf("vec%0d_gnt", v), 64'(core_gnt), 64'(vecs[v].exp_gnt));
            chk($sformatf("vec%0d_breq", v), 64'(bank_req), 64'(vecs[v].exp_breq));
            $display("vector %0d: req=%b gnt=%b bank_req=%h", v, vecs[v].req, core_gnt, bank_req);
        end

        // Single read through bank 1
        do_reset();
        set_core(0, 32'h0000_0044, 1'b0, 32'h0, 4'hF);
        bank_rdata[1] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rd_gnt", 64'(core_gnt), 64'h1);
        chk("rd_bank_req", 64'(bank_req), 64'h0002);
        chk("rd_bank_addr", 64'(bank_addr[1]), 64'((32'h44 / 64) % 1024));
        chk("rd_bank_wen", 64'(bank_wen[1]), 64'h0);
        step();
        core_req = '0;
        @(negedge clk);
        chk("rd_rvalid", 64'(core_rvalid), 64'h1);
        chk("rd_rdata", 64'(core_rdata[0]), 64'hDEAD_BEEF);
        $display("read seq: rvalid=%b rdata0=%h", core_rvalid, core_rdata[0]);

        // All cores hammer bank 5: rotation 0,1,2,3,0
        do_reset();
        for (int c = 0; c < NC; c++) set_core(c, 32'h14, 1'b0, 32'h0, 4'hF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("rr_gnt%0d", i), 64'(core_gnt), 64'(1) << (i % NC));
            if (i > 0) chk($sformatf("rr_rvalid%0d", i), 64'(core_rvalid), 64'(1) << ((i - 1) % NC));
            step();
        end
        $display("rotation seq done");

        // Partial-byte write through bank 7
        do_reset();
        set_core(2, 32'h0000_001C, 1'b1, 32'hCAFE_F00D, 4'b0011);
        bank_rdata[7] = 32'h5555_AAAA;
        @(negedge clk);
        chk("wr_gnt", 64'(core_gnt), 64'h4);
        chk("wr_bank_wen", 64'(bank_wen[7]), 64'h1);
        chk("wr_bank_be", 64'(bank_be[7]), 64'h3);
        chk("wr_bank_wdata", 64'(bank_wdata[7]), 64'hCAFE_F00D);
        step();
        core_req = '0;
        @(negedge clk);
        chk("wr_rvalid", 64'(core_rvalid), 64'h4);
        chk("wr_rdata", 64'(core_rdata[2]), 64'h0);
        $display("write seq: rvalid=%b rdata2=%h", core_rvalid, core_rdata[2]);

        // Pointer wrap on bank 3
        do_reset();
        set_core(2, 32'h0000_000C, 1'b0, 32'h0, 4'hF);
        @(negedge clk);
        chk("wrap_gnt2", 64'(core_gnt), 64'h4);
        step();
        idle();
        set_core(0, 32'h0000_000C, 1'b0, 32'h0, 4'hF);
        set_core(3, 32'h0000_000C, 1'b0, 32'h0, 4'hF);
        @(negedge clk);
        chk("wrap_gnt3", 64'(core_gnt), 64'h8);
        step();
        @(negedge clk);
        chk("wrap_gnt0", 64'(core_gnt), 64'h1);
        chk("wrap_rvalid3", 64'(core_rvalid), 64'h8);
        $display("wrap seq done");

        // Reset right after a grant; pointer for bank 9 must restart at 0
        do_reset();
        set_core(1, 32'h0000_0024, 1'b0, 32'h0, 4'hF);
        bank_rdata[9] = 32'h1234_5678;
        @(negedge clk);
        chk("mid_gnt1", 64'(core_gnt), 64'h2);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rvalid", 64'(core_rvalid), 64'h0);
        chk("mid_rdata", 64'(core_rdata[1]), 64'h0);
        chk("mid_gnt", 64'(core_gnt), 64'h0);
        chk("mid_breq", 64'(bank_req), 64'h0);
        step();
        rst = 1'b0;
        for (int c = 0; c < NC; c++) set_core(c, 32'h0000_0024, 1'b0, 32'h0, 4'hF);
        @(negedge clk);
        chk("post_rst_gnt", 64'(core_gnt), 64'h1);
        chk("post_rst_rvalid", 64'(core_rvalid), 64'h0);
        $display("reset seq done");

        // Randomized run against the reference model
        do_reset();
        for (int b = 0; b < NB; b++) m_rr[b] = 0;
        for (int c = 0; c < NC; c++) begin
            m_pv[c] = 1'b0; m_pb[c] = 0; m_pw[c] = 1'b0;
        end
        last_gnt = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int c = 0; c < NC; c++) begin
                if (!(core_req[c] && !last_gnt[c])) begin
                    bsel          = $urandom_range(0, 3);
                    core_req[c]   = ($urandom_range(0, 2) != 0);
                    core_addr[c]  = ($urandom() & 32'hFFFF_FFC3) | (32'(bsel) << 2);
                    core_wen[c]   = 1'($urandom_range(0, 1));
                    core_wdata[c] = $urandom();
                    core_be[c]    = 4'($urandom());
                end
            end
            for (int b = 0; b < NB; b++) bank_rdata[b] = $urandom();
            @(negedge clk);
            m_gnt = '0;
            for (int b = 0; b < NB; b++) begin
                win = -1;
                for (int k = 0; k < NC; k++) begin
                    int c;
                    c = (m_rr[b] + k) % NC;
                    if (win < 0 && core_req[c] && ((core_addr[c] / 4) % NB) == b) win = c;
                end
                chk($sformatf("rnd_breq_b%0d", b), 64'(bank_req[b]), 64'(win >= 0));
                if (win >= 0) begin
                    m_gnt[win] = 1'b1;
                    chk("rnd_baddr", 64'(bank_addr[b]), 64'((core_addr[win] / 64) % 1024));
                    chk("rnd_bwen", 64'(bank_wen[b]), 64'(core_wen[win]));
                    chk("rnd_bwdata", 64'(bank_wdata[b]), 64'(core_wdata[win]));
                    chk("rnd_bbe", 64'(bank_be[b]), 64'(core_be[win]));
                    m_rr[b] = (win + 1) % NC;
                end else begin
                    chk("rnd_idle_bank", 64'({bank_addr[b], bank_wdata[b], bank_be[b]}), 64'h0);
                end
            end
            chk("rnd_gnt", 64'(core_gnt), 64'(m_gnt));
            for (int c = 0; c < NC; c++) begin
                chk("rnd_rvalid", 64'(core_rvalid[c]), 64'(m_pv[c]));
                chk("rnd_rdata", 64'(core_rdata[c]),
                    (m_pv[c] && !m_pw[c]) ? 64'(bank_rdata[m_pb[c]]) : 64'h0);
            end
            for (int c = 0; c < NC; c++) begin
                m_pv[c] = m_gnt[c];
                m_pb[c] = (core_addr[c] / 4) % NB;
                m_pw[c] = core_wen[c];
            end
            last_gnt = m_gnt;
            step();
        end
        $display("random run: 1500 cycles");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
